// File: rtl/custom_counter_param.sv
// Synchronous modulo-N up/down counter with load, prescaler, tick output and
// overflow pulse/sticky flag. Drives digit scan and timebase for the mux display.
module custom_counter_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [PRE_W-1:0] prescale,
  output logic             adv
);
  logic [PRE_W-1:0] pc;
  logic             term;

  assign term = (pc == prescale);
  assign adv  = en && !load && term;

  // If prescale drops below pc, pc runs up through all-ones and wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= '0;
    else if (load)    pc <= '0;
    else if (en)      pc <= term ? '0 : PRE_W'(pc + 1'b1);
  end
endmodule

module custom_counter_param #(
  parameter int               WIDTH     = 10,
  parameter int               PRE_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] top,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             ovf,
  output logic             ovf_sticky
);
  logic             adv;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;

  custom_counter_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .prescale (prescale),
    .adv      (adv)
  );

  // Priority: load > advance > hold. Out-of-range counts snap back into 0..top.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    if (load) begin
      count_nxt = data;
    end else if (adv) begin
      if (dir) begin
        if (count >= top) begin
          count_nxt = '0;
          ovf_nxt   = 1'b1;
        end else begin
          count_nxt = WIDTH'(count + 1'b1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = top;
          ovf_nxt   = 1'b1;
        end else if (count > top) begin
          count_nxt = top;
        end else begin
          count_nxt = WIDTH'(count - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= RESET_VAL;
      tick       <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= count_nxt;
      tick  <= adv;
      ovf   <= ovf_nxt;
      // Set beats a simultaneous clear.
      if (ovf_nxt)      ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
    end
  end
endmodule
